mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter that shares the core's single unified memory port between instruction fetch and load/store data access. It sits between `core` and `memory` in `top`, replacing the direct fetch/data muxing. It serialises one transaction at a time through a request/response handshake and aborts transactions that stall past a timeout. It gives the multi-cycle control FSM a stable single-port view today and allows a fetch-ahead unit to be added later.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes
- `TIMEOUT`, 255, maximum cycles from leaving IDLE to a response before abort; ≥ 2
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch request accepted (combinational)
- `if_rvalid`  out  1  one-cycle fetch response strobe
- `if_rdata`  out  DATA_W  fetch data, valid with `if_rvalid`
- `d_req`  in  1  data request, held until `d_gnt`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  store byte enables
- `d_gnt`  out  1  data request accepted (combinational)
- `d_rvalid`  out  1  one-cycle data response strobe; also acknowledges stores
- `d_rdata`  out  DATA_W  load data, valid with `d_rvalid`
- `mem_valid`  out  1  command valid to memory
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  registered command fields
- `mem_ready`  in  1  memory accepts command
- `mem_rvalid`  in  1  memory response; every command returns exactly one
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state ≠ IDLE
- `err_timeout`  out  1  one-cycle pulse on abort

## Operation
- States:
  - IDLE: no transaction in flight.
  - ISSUE: `mem_valid`=1.
  - WAIT: awaiting `mem_rvalid`.
  - RESP: owner `*_rvalid`=1.
- IDLE: if any request is pending, select a winner, assert its `*_gnt`, and latch its command, the owner and the `mem_*` registers. Next state ISSUE, counter cleared. A loser's `gnt` stays 0; it keeps requesting.
- Winner selection: data always wins a tie.
- ISSUE → WAIT on `mem_ready`. Any `mem_rvalid` seen in ISSUE is ignored; memory must respond at least 1 cycle after `mem_ready`.
- WAIT → RESP on `mem_rvalid`. Capture `mem_rdata` into the owner's rdata register. For stores, rdata is captured but don't-care.
- RESP → IDLE unconditionally. The non-owner's `rvalid` never asserts.
- Timeout: a counter increments every cycle in ISSUE and WAIT. When it reaches `TIMEOUT`, go to RESP with owner rdata = 0, pulse `err_timeout` in that RESP cycle, and deassert `mem_valid`. A late `mem_rvalid` arriving in IDLE is ignored.
- `*_rdata` hold their last value outside RESP.

## Timing
- Reset (asynchronous) drives all of the following to 0 and abandons any in-flight transaction with no response:
  - state = IDLE, counter, owner
  - `mem_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`
  - `if_rvalid`, `d_rvalid`, `if_rdata`, `d_rdata`
  - `busy`, `err_timeout`
- The `gnt` outputs are combinational from IDLE & req, so they are 0 during reset.
- Minimum latency:
  - Cycle 0: `gnt`.
  - Cycle 1: `mem_valid` (ready same cycle).
  - Cycle 2: `mem_rvalid`.
  - Cycle 3: `rvalid`.
  - Cycle 4: next `gnt` at the earliest.
- Throughput: 1 transaction per ≥4 cycles.
- `mem_*` command fields are stable from ISSUE entry until `mem_ready`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: a tie goes to the requester not served last. The last-served register resets to fetch, so data wins the first tie after reset.
  - Undefined: fixed priority, data over fetch, and the last-served register is absent.
  - Non-tie behaviour is identical in both builds.

## Structure
- Add to `src/types.svh` as the shared package:
  - `typedef enum` `mem_arb_state_t` {`MEM_ARB__IDLE`, `MEM_ARB__ISSUE`, `MEM_ARB__WAIT`, `MEM_ARB__RESP`}.
  - `mem_arb_owner_t` {`MEM_ARB_OWNER__FETCH`, `MEM_ARB_OWNER__DATA`}.
- One sub-module, `mem_arb_pick`: combinational winner selection from `if_req`, `d_req` and the last owner, with its round-robin logic under the macro.

## Test plan
- Fetch only: `if_addr`=0x0, memory returns 0x010000EF with ready immediate and rvalid one cycle later.
  - `if_gnt` in cycle 0, `mem_addr`=0x0 in cycle 1.
  - `if_rvalid` with `if_rdata`=0x010000EF in cycle 3.
  - `d_rvalid` stays 0.
- Store: `d_we`=1, `d_addr`=0x40, `d_wdata`=0x4, `d_wstrb`=0xF.
  - `mem_we`=1 with matching fields while `mem_valid`.
  - `d_rvalid` pulses once.
- Tie, fixed priority: both requests in the same cycle.
  - `d_gnt` first, `if_gnt` in the first IDLE after `d_rvalid`.
- Tie with `MEM_ARB_ROUND_ROBIN_EN`: three consecutive ties.
  - Grant order is data, fetch, data.
- Timeout: `TIMEOUT`=8 and memory never asserts `mem_ready`.
  - `err_timeout` and `if_rvalid` pulse with rdata=0 in the RESP cycle.
  - `busy` drops the following cycle.
- Reset mid-WAIT: assert reset between cycle edges.
  - All outputs are 0 immediately.
  - After release, a new fetch completes normally with no stale `rvalid`.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg : shared state and owner types for the memory arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ARB__IDLE  = 2'd0,
        MEM_ARB__ISSUE = 2'd1,
        MEM_ARB__WAIT  = 2'd2,
        MEM_ARB__RESP  = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        MEM_ARB_OWNER__FETCH = 1'b0,
        MEM_ARB_OWNER__DATA  = 1'b1
    } mem_arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ----------------------------------------------------------------------------
// mem_arb_pick : combinational winner selection between fetch and data
// Rev 1.0 -- round-robin tie break under MEM_ARB_ROUND_ROBIN_EN
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_owner,
    output logic any_req,
    output logic pick_data
);

    assign any_req = if_req || d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie, serve whoever was not served last.
    assign pick_data = d_req && (!if_req || (last_owner != MEM_ARB_OWNER__DATA));
`else
    logic unused_last;
    assign unused_last = last_owner;
    assign pick_data   = d_req;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter : fetch/data arbiter onto a single memory port with timeout abort
// Rev 1.0 -- define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking
// ----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                err_timeout
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_arb_state_t   state;
    mem_arb_owner_t   owner;
    logic [CNT_W-1:0] count;

    logic              any_req;
    logic              pick_data;
    logic              grant;
    logic              in_flight;
    logic              take_rsp;
    logic              abort;
    logic              finish;
    logic [DATA_W-1:0] resp_data;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (owner),
        .any_req    (any_req),
        .pick_data  (pick_data)
    );

    assign grant  = (state == MEM_ARB__IDLE) && !reset && any_req;
    assign d_gnt  = grant && pick_data;
    assign if_gnt = grant && !pick_data;
    assign busy   = (state != MEM_ARB__IDLE);

    // A real response in the final counted cycle beats the abort.
    assign in_flight = (state == MEM_ARB__ISSUE) || (state == MEM_ARB__WAIT);
    assign take_rsp  = (state == MEM_ARB__WAIT) && mem_rvalid;
    assign abort     = in_flight && (count == CNT_LAST) && !take_rsp;
    assign finish    = take_rsp || abort;
    assign resp_data = take_rsp ? mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= MEM_ARB__IDLE;
            owner       <= MEM_ARB_OWNER__FETCH;
            count       <= '0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            if_rvalid   <= 1'b0;
            d_rvalid    <= 1'b0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= abort;
            if_rvalid   <= finish && (owner == MEM_ARB_OWNER__FETCH);
            d_rvalid    <= finish && (owner == MEM_ARB_OWNER__DATA);
            if (finish && (owner == MEM_ARB_OWNER__FETCH)) begin
                if_rdata <= resp_data;
            end
            if (finish && (owner == MEM_ARB_OWNER__DATA)) begin
                d_rdata <= resp_data;
            end

            unique case (state)
                MEM_ARB__IDLE: begin
                    if (grant) begin
                        state     <= MEM_ARB__ISSUE;
                        count     <= '0;
                        mem_valid <= 1'b1;
                        if (pick_data) begin
                            owner     <= MEM_ARB_OWNER__DATA;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wstrb <= d_wstrb;
                        end else begin
                            owner     <= MEM_ARB_OWNER__FETCH;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                MEM_ARB__ISSUE, MEM_ARB__WAIT: begin
                    count <= count + 1'b1;
                    if (finish) begin
                        state     <= MEM_ARB__RESP;
                        mem_valid <= 1'b0;
                    end else if ((state == MEM_ARB__ISSUE) && mem_ready) begin
                        state     <= MEM_ARB__WAIT;
                        mem_valid <= 1'b0;
                    end
                end
                MEM_ARB__RESP: begin
                    state <= MEM_ARB__IDLE;
                end
                default: begin
                    state <= MEM_ARB__IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
